hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard.sv | 89 ++++++++
 tb/tb_hazard_scoreboard.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// In-order pipeline hazard scoreboard: tracks in-flight writers per stage, selects
// operand forwarding sources and raises a zero-latency load-use stall at decode.
module hazard_scoreboard #(
  parameter int STAGES     = 3,
  parameter int RA_W       = 5,
  parameter int LOAD_STAGE = 2,
  parameter int SEL_W      = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic             id_wen,
  input  logic [RA_W-1:0]  id_dst,
  input  logic             id_is_load,
  input  logic             flush,
  output logic             stall,
  output logic [SEL_W-1:0] fwd_rs,
  output logic [SEL_W-1:0] fwd_rt,
  output logic [15:0]      stall_cnt
);

  logic [STAGES:1] r_vld;
  logic [STAGES:1] r_wen;
  logic [STAGES:1] r_ld;
  logic [RA_W-1:0] r_dst [1:STAGES];
  logic [15:0]     r_cnt;

  logic             w_rs_hit, w_rs_rdy, w_rt_hit, w_rt_rdy;
  logic [SEL_W-1:0] w_rs_sel, w_rt_sel;
  logic             w_load_s1;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Scan oldest to youngest so the youngest match (lowest stage) wins.
  always_comb begin
    w_rs_hit = 1'b0;
    w_rs_rdy = 1'b1;
    w_rs_sel = '0;
    w_rt_hit = 1'b0;
    w_rt_rdy = 1'b1;
    w_rt_sel = '0;
    for (int k = STAGES; k >= 1; k--) begin
      if (r_vld[k] && r_wen[k] && (r_dst[k] == id_rs) && (id_rs != '0) && id_rs_used) begin
        w_rs_hit = 1'b1;
        w_rs_sel = SEL_W'(k);
        w_rs_rdy = !r_ld[k] || (k >= LOAD_STAGE);
      end
      if (r_vld[k] && r_wen[k] && (r_dst[k] == id_rt) && (id_rt != '0) && id_rt_used) begin
        w_rt_hit = 1'b1;
        w_rt_sel = SEL_W'(k);
        w_rt_rdy = !r_ld[k] || (k >= LOAD_STAGE);
      end
    end
  end

  // Outputs are forced quiet while reset is asserted, even before the first edge.
  assign stall     = rst_n & id_valid & ~flush &
                     ((w_rs_hit & ~w_rs_rdy) | (w_rt_hit & ~w_rt_rdy));
  assign fwd_rs    = (rst_n && w_rs_hit && w_rs_rdy) ? w_rs_sel : '0;
  assign fwd_rt    = (rst_n && w_rt_hit && w_rt_rdy) ? w_rt_sel : '0;
  assign stall_cnt = rst_n ? r_cnt : '0;
  assign w_load_s1 = id_valid & ~stall & ~flush;

  // Stage boundary: decode -> stage 1, stage k -> stage k+1 (control).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld <= '0;
      r_cnt <= '0;
    end else begin
      r_vld <= {r_vld[STAGES-1:1], w_load_s1};
      if (stall) r_cnt <= sat_inc(r_cnt);
    end
  end

  // Stage boundary: payload moves alongside the valid bits, no reset needed.
  always_ff @(posedge clk) begin
    r_wen    <= {r_wen[STAGES-1:1], id_wen};
    r_ld     <= {r_ld[STAGES-1:1], id_is_load};
    r_dst[1] <= id_dst;
    for (int k = 2; k <= STAGES; k++) r_dst[k] <= r_dst[k-1];
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: issue-history model with per-cycle compare, directed
// hazard scenarios, plus a deep-pipeline instance to drive the stall counter to saturation.
module tb_hazard_scoreboard;
  localparam int ST = 3;
  localparam int LS = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, id_valid, id_rs_used, id_rt_used, id_wen, id_is_load, flush;
  logic [4:0] id_rs, id_rt, id_dst;
  logic       stall;
  logic [1:0] fwd_rs, fwd_rt;
  logic [15:0] stall_cnt;

  logic       rst_n2, v2, rsu2, rtu2, wen2, ld2, fl2;
  logic [4:0] rs2, rt2, dst2;
  logic       stall2;
  logic [3:0] fwd_rs2, fwd_rt2;
  logic [15:0] stall_cnt2;

  hazard_scoreboard #(.STAGES(ST), .RA_W(5), .LOAD_STAGE(LS), .SEL_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_wen(id_wen), .id_dst(id_dst),
    .id_is_load(id_is_load), .flush(flush), .stall(stall), .fwd_rs(fwd_rs),
    .fwd_rt(fwd_rt), .stall_cnt(stall_cnt));

  hazard_scoreboard #(.STAGES(8), .RA_W(5), .LOAD_STAGE(8), .SEL_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n2), .id_valid(v2), .id_rs(rs2), .id_rt(rt2),
    .id_rs_used(rsu2), .id_rt_used(rtu2), .id_wen(wen2), .id_dst(dst2),
    .id_is_load(ld2), .flush(fl2), .stall(stall2), .fwd_rs(fwd_rs2),
    .fwd_rt(fwd_rt2), .stall_cnt(stall_cnt2));

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: a list of issued writers stamped with their issue cycle; age = stage.
  typedef struct { int cyc; logic wen; logic [4:0] dst; logic ld; } rec_t;
  rec_t q[$];
  int   now = 0;
  int   mcnt = 0;
  logic m_stall = 1'b0;

  function automatic void lookup(input logic [4:0] src, input logic used,
                                 output int sel, output bit haz);
    int  best;
    logic bld;
    best = 99;
    bld  = 1'b0;
    sel  = 0;
    haz  = 1'b0;
    if (!used || src == 5'd0) return;
    foreach (q[i]) begin
      if (q[i].wen && q[i].dst == src && (now - q[i].cyc) < best) begin
        best = now - q[i].cyc;
        bld  = q[i].ld;
      end
    end
    if (best == 99) return;
    if (bld && best < LS) haz = 1'b1;
    else sel = best;
  endfunction

  always @(negedge clk) begin : cmp
    int srs, srt;
    bit hrs, hrt;
    lookup(id_rs, id_rs_used, srs, hrs);
    lookup(id_rt, id_rt_used, srt, hrt);
    m_stall = rst_n && id_valid && !flush && (hrs || hrt);
    chk("mdl_stall", stall, m_stall);
    chk("mdl_fwd_rs", fwd_rs, rst_n ? srs : 0);
    chk("mdl_fwd_rt", fwd_rt, rst_n ? srt : 0);
    chk("mdl_cnt", stall_cnt, rst_n ? mcnt : 0);
  end

  always @(posedge clk) begin : mdl
    rec_t r;
    if (!rst_n) begin
      q.delete();
      mcnt = 0;
    end else begin
      if (m_stall && mcnt < 65535) mcnt++;
      if (id_valid && !m_stall && !flush) begin
        r.cyc = now; r.wen = id_wen; r.dst = id_dst; r.ld = id_is_load;
        q.push_back(r);
      end
    end
    now++;
    while (q.size() > 0 && (now - q[0].cyc) > ST) void'(q.pop_front());
  end

  task automatic put(input logic v, input logic [4:0] rs, input logic rsu, input logic [4:0] rt,
                     input logic rtu, input logic w, input logic [4:0] d, input logic ld,
                     input logic fl);
    id_valid = v; id_rs = rs; id_rs_used = rsu; id_rt = rt; id_rt_used = rtu;
    id_wen = w; id_dst = d; id_is_load = ld; flush = fl;
  endtask

  task automatic put2(input logic v, input logic [4:0] rt, input logic rtu, input logic w,
                      input logic [4:0] d, input logic ld);
    v2 = v; rs2 = 5'd0; rsu2 = 1'b0; rt2 = rt; rtu2 = rtu;
    wen2 = w; dst2 = d; ld2 = ld; fl2 = 1'b0;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string nm, input logic s, input logic [1:0] frs, input logic [1:0] frt);
    chk({nm, "_stall"}, stall, s);
    chk({nm, "_fwd_rs"}, fwd_rs, frs);
    chk({nm, "_fwd_rt"}, fwd_rt, frt);
  endtask

  task automatic drain;
    put(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    rst_n2 = 1'b0;
    put(0, 0, 0, 0, 0, 0, 0, 0, 0);
    put2(0, 0, 0, 0, 0, 0);
    tick();
    @(negedge clk); lit("in_reset", 0, 0, 0); chk("in_reset_cnt", stall_cnt, 0);
    tick();
    rst_n = 1'b1;
    @(negedge clk); lit("post_reset", 0, 0, 0); chk("post_reset_cnt", stall_cnt, 0);
    tick();

    // ALU result walks EX -> MEM -> WB -> register file
    put(1, 9, 1, 10, 1, 1, 8, 0, 0); @(negedge clk); tick();
    put(1, 8, 1, 3, 1, 1, 4, 0, 0); @(negedge clk); lit("alu_c1", 0, 1, 0); tick();
    put(1, 8, 1, 0, 0, 0, 0, 0, 0); @(negedge clk); lit("alu_c2", 0, 2, 0); tick();
    @(negedge clk); lit("alu_c3", 0, 3, 0); tick();
    @(negedge clk); lit("alu_c4", 0, 0, 0); tick();
    drain();

    // load-use: one stall cycle, then forward from MEM
    put(1, 29, 1, 0, 0, 1, 8, 1, 0); @(negedge clk); tick();
    put(1, 9, 1, 8, 1, 1, 10, 0, 0); @(negedge clk); lit("ldu_c1", 1, 0, 0);
    chk("ldu_c1_cnt", stall_cnt, 0); tick();
    @(negedge clk); lit("ldu_c2", 0, 0, 2); chk("ldu_c2_cnt", stall_cnt, 1); tick();
    drain();

    // two writers of $8: youngest wins
    put(1, 0, 0, 0, 0, 1, 8, 0, 0); @(negedge clk); tick();
    put(1, 8, 1, 0, 0, 1, 8, 0, 0); @(negedge clk); lit("young_c1", 0, 1, 0); tick();
    put(1, 8, 1, 0, 0, 0, 0, 0, 0); @(negedge clk); lit("young_c2", 0, 1, 0); tick();
    drain();

    // rs forwards while rt stalls on a load; fwd still reported during stall
    put(1, 0, 0, 0, 0, 1, 9, 0, 0); @(negedge clk); tick();
    put(1, 0, 0, 0, 0, 1, 8, 1, 0); @(negedge clk); tick();
    put(1, 9, 1, 8, 1, 0, 0, 0, 0); @(negedge clk); lit("mix_c2", 1, 2, 0); tick();
    @(negedge clk); lit("mix_c3", 0, 3, 2); chk("mix_cnt", stall_cnt, 2); tick();
    drain();

    // flush beats stall and squashes the decode instruction
    put(1, 0, 0, 0, 0, 1, 8, 1, 0); @(negedge clk); tick();
    put(1, 0, 0, 8, 1, 1, 9, 0, 1); @(negedge clk); lit("flush_c1", 0, 0, 0); tick();
    put(1, 9, 1, 8, 1, 0, 0, 0, 0); @(negedge clk); lit("flush_c2", 0, 0, 2);
    chk("flush_cnt", stall_cnt, 2); tick();
    drain();

    // register $0 never matches; unused sources never match
    put(1, 0, 0, 0, 0, 1, 0, 1, 0); @(negedge clk); tick();
    put(1, 0, 1, 0, 1, 0, 0, 0, 0); @(negedge clk); lit("zero_reg", 0, 0, 0); tick();
    drain();
    put(1, 0, 0, 0, 0, 1, 8, 0, 0); @(negedge clk); tick();
    put(1, 8, 0, 8, 1, 0, 0, 0, 0); @(negedge clk); lit("unused_src", 0, 0, 1); tick();
    drain();

    // reset discards in-flight writers
    put(1, 0, 0, 0, 0, 1, 8, 0, 0); @(negedge clk); tick();
    rst_n = 1'b0;
    put(1, 8, 1, 0, 0, 0, 0, 0, 0); @(negedge clk); lit("rst_in", 0, 0, 0);
    chk("rst_in_cnt", stall_cnt, 0); tick();
    rst_n = 1'b1;
    @(negedge clk); lit("rst_after", 0, 0, 0); chk("rst_after_cnt", stall_cnt, 0); tick();
    drain();

    // deep-pipeline instance: 7 stall cycles per 8-cycle group
    rst_n2 = 1'b1;
    for (int g = 0; g < 9393; g++) begin
      for (int c = 0; c < 8; c++) begin
        if (c == 0) put2(1, 0, 0, 1, 8, 1);
        else        put2(1, 8, 1, 0, 0, 0);
        if (g < 3) begin
          @(negedge clk);
          chk("deep_stall", stall2, (c != 0));
        end
        tick();
        if (g == 9361 && c == 7) begin
          @(negedge clk); chk("sat_pre", stall_cnt2, 16'hFFFE);
        end
        if (g == 9362 && c == 7) begin
          @(negedge clk); chk("sat_hit", stall_cnt2, 16'hFFFF);
        end
      end
    end
    @(negedge clk); chk("sat_hold", stall_cnt2, 16'hFFFF);

    // reset in the middle of a stall
    put2(1, 0, 0, 1, 8, 1); tick();
    put2(1, 8, 1, 0, 0, 0); @(negedge clk); chk("rst2_stalling", stall2, 1); tick();
    rst_n2 = 1'b0;
    @(negedge clk); chk("rst2_in_stall", stall2, 0); chk("rst2_in_cnt", stall_cnt2, 0); tick();
    rst_n2 = 1'b1;
    @(negedge clk);
    chk("rst2_after_stall", stall2, 0);
    chk("rst2_after_fwd_rs", fwd_rs2, 0);
    chk("rst2_after_fwd_rt", fwd_rt2, 0);
    chk("rst2_after_cnt", stall_cnt2, 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
